// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider for the lab 5 arithmetic datapath.
// Operands are captured from the switch bus while idle; on Run the block
// runs WIDTH shift/trial-subtract iterations (two states per bit) and holds
// the quotient/remainder for the displays until the next start.
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Load_Dividend,
    input  logic             Load_Divisor,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TRIAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] q;
    // One extra bit: after a shift the partial remainder can reach 2*DVS-1.
    logic [WIDTH:0]   r;
    logic [CW-1:0]    cnt;

    // Trial subtraction of the divisor from the shifted partial remainder.
    logic [WIDTH:0]   r_diff;
    logic             r_ge;
    always_comb begin
        r_diff = r - {1'b0, dvs};
        r_ge   = (r >= {1'b0, dvs});
    end

    // Control FSM and datapath; Busy/Done are registered alongside the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            q         <= '0;
            r         <= '0;
            cnt       <= '0;
            DivByZero <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Loads still apply on the start edge; Q takes the old DVD.
                    if (Load_Dividend) dvd <= Din;
                    if (Load_Divisor)  dvs <= Din;
                    if (Run) begin
                        if (dvs != '0) begin
                            r         <= '0;
                            q         <= dvd;
                            cnt       <= '0;
                            DivByZero <= 1'b0;
                            state     <= SHIFT;
                            Busy      <= 1'b1;
                            Done      <= 1'b0;
                        end else begin
                            q         <= '1;
                            r         <= {1'b0, dvd};
                            DivByZero <= 1'b1;
                            state     <= DONE;
                            Busy      <= 1'b0;
                            Done      <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r     <= {r[WIDTH-1:0], q[WIDTH-1]};
                    q     <= {q[WIDTH-2:0], 1'b0};
                    state <= TRIAL;
                end
                TRIAL: begin
                    if (r_ge) begin
                        r    <= r_diff;
                        q[0] <= 1'b1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    // No auto-restart: Run must be released first.
                    if (!Run) begin
                        state <= IDLE;
                        Done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

    assign Quotient  = q;
    assign Remainder = r[WIDTH-1:0];

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: expected results are queued when a
// division is launched and compared when Done rises.
module tb_restoring_divider;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Run = 1'b0;
    logic         Load_Dividend = 1'b0;
    logic         Load_Divisor = 1'b0;
    logic [W-1:0] Din = '0;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;

    restoring_divider #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run),
        .Load_Dividend(Load_Dividend), .Load_Divisor(Load_Divisor),
        .Din(Din), .Quotient(Quotient), .Remainder(Remainder),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0;
    int   miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        Din = a; Load_Dividend = 1'b1;
        @(negedge Clk);
        Load_Dividend = 1'b0; Din = b; Load_Divisor = 1'b1;
        @(negedge Clk);
        Load_Divisor = 1'b0; Din = '0;
    endtask

    // Expected result is computed here from the operands, not from the DUT.
    task automatic expect_div(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.lat = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = 2 * W;
        end
        sb.push_back(e);
    endtask

    // Launch a division; inj >= 0 pulses Load_Divisor with Din=3 at that cycle.
    task automatic do_div(input string tag, input logic hold, input int inj);
        int   cyc;
        int   busy_n;
        exp_t e;
        @(negedge Clk);
        Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        if (!hold) Run = 1'b0;
        cyc = 0; busy_n = 0;
        while (!Done && cyc < 60) begin
            if (Busy) busy_n++;
            if (cyc == inj) begin Load_Divisor = 1'b1; Din = 8'd3; end
            else begin Load_Divisor = 1'b0; Din = '0; end
            @(negedge Clk);
            cyc++;
        end
        Load_Divisor = 1'b0; Din = '0;
        chk({tag, "_done"}, Done, 1);
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_latency"}, cyc, e.lat);
            chk({tag, "_busy_cycles"}, busy_n, e.lat);
            chk({tag, "_quotient"}, Quotient, e.q);
            chk({tag, "_remainder"}, Remainder, e.r);
            chk({tag, "_dbz"}, DivByZero, e.dbz);
        end
    endtask

    initial begin
        int bad;
        // Reset state
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_q", Quotient, 0);
        chk("rst_r", Remainder, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_dbz", DivByZero, 0);

        // 100 / 7, then release Run: outputs held in IDLE
        load(8'd100, 8'd7);
        expect_div(8'd100, 8'd7);
        do_div("d100_7", 1'b0, -1);
        @(negedge Clk);
        chk("idle_done", Done, 0);
        chk("idle_busy", Busy, 0);
        chk("idle_q_hold", Quotient, 14);
        chk("idle_r_hold", Remainder, 2);

        load(8'd255, 8'd1);   expect_div(8'd255, 8'd1);   do_div("d255_1", 1'b0, -1);
        load(8'd5, 8'd9);     expect_div(8'd5, 8'd9);     do_div("d5_9", 1'b0, -1);
        load(8'd200, 8'd200); expect_div(8'd200, 8'd200); do_div("d200_200", 1'b0, -1);

        // Divide by zero, then a valid division clears the flag
        load(8'd42, 8'd0);    expect_div(8'd42, 8'd0);    do_div("dz42", 1'b0, -1);
        load(8'd9, 8'd3);     expect_div(8'd9, 8'd3);     do_div("d9_3", 1'b0, -1);

        // Reset in the middle of a division
        load(8'd100, 8'd7);
        @(negedge Clk); Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk); Run = 1'b0;
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("mid_rst_q", Quotient, 0);
        chk("mid_rst_r", Remainder, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_done", Done, 0);
        load(8'd100, 8'd7);   expect_div(8'd100, 8'd7);   do_div("after_rst", 1'b0, -1);

        // Run held high: one division only, stays in DONE
        load(8'd50, 8'd6);    expect_div(8'd50, 8'd6);    do_div("hold50_6", 1'b1, -1);
        bad = 0;
        repeat (22) begin
            @(negedge Clk);
            if (!Done || Busy || Quotient != 8'd8 || Remainder != 8'd2) bad++;
        end
        chk("hold_stays_done", bad, 0);
        Run = 1'b0;
        @(negedge Clk);
        chk("hold_release_done", Done, 0);
        expect_div(8'd50, 8'd6);  do_div("hold_restart", 1'b0, -1);

        // Divisor load while busy is ignored
        load(8'd100, 8'd7);   expect_div(8'd100, 8'd7);   do_div("ld_busy", 1'b0, 3);
        expect_div(8'd100, 8'd7); do_div("ld_busy_rerun", 1'b0, -1);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
